// File: rtl/vector_word_assembler.sv
// -----------------------------------------------------------------------------
// vector_word_assembler
//
// Packs a byte stream (byte 0 first, bit 0 of each byte first) into 32-bit
// words in internal bit order: word = bitrev32({b3,b2,b1,b0}). A frame is
// TOTAL_BYTES long. A short final word is zero-padded, and the last word of
// each frame is flagged. Completed words wait in a one-entry output register
// until the sink takes them.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   byte_in     input byte
//   byte_valid  byte_in is valid
//   byte_ready  block accepts a byte this cycle
//   word_out    assembled word, internal bit order
//   word_valid  word_out / word_addr / word_last are valid
//   word_ready  sink accepts the word this cycle
//   word_addr   word index within the frame, 0..NWORDS-1
//   word_last   word_out is the final word of the frame
// -----------------------------------------------------------------------------
module vector_word_assembler #(
  parameter int TOTAL_BYTES = 436,
  localparam int NWORDS = (TOTAL_BYTES + 3) / 4,
  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic [31:0]   word_out,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [AW-1:0] word_addr,
  output logic          word_last
);

  localparam int BW = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(TOTAL_BYTES - 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(NWORDS - 1);

  logic [31:0]   asm_q, asm_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]   out_word_q, out_word_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_last_q, out_last_d;
  logic          out_valid_q, out_valid_d;

  logic [7:0]    byte_rev;
  logic [31:0]   merged;
  logic          is_last_byte;
  logic          completing_byte;
  logic          accept;
  logic          drain;

  // Bit 0 of the arriving byte lands in the most significant position of its
  // slot field.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rev
    assign byte_rev[gi] = byte_in[7-gi];
  end

  // Slot k occupies word bits [31-8k -: 8]. Slots already filled come from the
  // assembly register, the current slot takes the incoming byte, and slots not
  // yet reached are forced to zero so nothing stale can escape on a short word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    assign merged[31-8*gi -: 8] = (cnt_q == 2'(gi)) ? byte_rev :
                                  (cnt_q >  2'(gi)) ? asm_q[31-8*gi -: 8] :
                                                      8'h00;
  end

  assign is_last_byte    = (byte_cnt_q == LAST_BYTE);
  assign completing_byte = (cnt_q == 2'd3) || is_last_byte;

  // Only a word-completing byte needs room in the output register; that room
  // exists if the register is empty or is being drained this same cycle.
  assign byte_ready = !rst && (!completing_byte || !out_valid_q || word_ready);
  assign accept     = byte_valid && byte_ready;
  assign drain      = out_valid_q && word_ready;

  always_comb begin
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (drain) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      byte_cnt_d = is_last_byte ? '0 : byte_cnt_q + BW'(1);
      if (completing_byte) begin
        // A reload here overrides the drain above.
        out_word_d  = merged;
        out_addr_d  = word_cnt_q;
        out_last_d  = (word_cnt_q == LAST_WORD);
        out_valid_d = 1'b1;
        asm_d       = '0;
        cnt_d       = '0;
        word_cnt_d  = is_last_byte ? '0 : word_cnt_q + AW'(1);
      end else begin
        asm_d = merged;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign word_out   = out_word_q;
  assign word_addr  = out_addr_q;
  assign word_last  = out_last_q;
  assign word_valid = out_valid_q;

endmodule

// File: doc/vector_word_assembler.md
# vector_word_assembler

Byte-stream to 32-bit word assembler for error-vector and key data entering the Classic McEliece core. Accepts one byte per cycle in external order (byte 0 first, bit 0 of each byte first) and emits 32-bit words in internal bit order. Internal order is the full 32-bit bit reversal of the little-endian packed bytes. The block sits between the byte-wide I/O front end and the word-wide vector/key RAM write port. It tracks frame length, zero-pads a short final word, and flags the last word of each frame.

## Interface
- TOTAL_BYTES, 436: bytes per frame (436 = 3488-bit vector); any value ≥ 1.
- NWORDS (derived, localparam): ceil(TOTAL_BYTES/4); AW = max(1, $clog2(NWORDS)).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- byte_in  in  8  input byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  block can accept a byte this cycle.
- word_out  out  32  assembled word, internal order.
- word_valid  out  1  word_out/word_addr/word_last valid.
- word_ready  in  1  sink accepts word this cycle.
- word_addr  out  AW  word index within frame, 0..NWORDS-1.
- word_last  out  1  word_out is final word of frame.

## Operation
- Byte transfer occurs when byte_valid && byte_ready. Word transfer occurs when word_valid && word_ready.
- Bit mapping: for arrival slot k (0..3) within a word and bit m (0..7), word_out[31-8k-m] = byte_k[m]. Equivalently, word_out = bitrev32({b3,b2,b1,b0}).
- State:
  - assembly register (32 b);
  - slot counter cnt (0..3);
  - frame byte counter (0..TOTAL_BYTES-1);
  - word counter (0..NWORDS-1);
  - one-entry output register holding word_out, word_addr, word_last and word_valid.
- Accepted byte writes its slot; cnt increments.
- The word completes when the 4th byte is accepted, or when the frame's final byte (byte counter = TOTAL_BYTES-1) is accepted.
  - Unfilled slots are forced to zero. Stale assembly contents must never leak into the word.
  - On completion the word loads into the output register with word_addr = word counter and word_last = (word counter = NWORDS-1).
  - Assembly and cnt clear in the same cycle.
- Frame wrap: after the final byte, the byte counter and word counter return to 0. The next byte starts a new frame with no idle cycle required.
- byte_ready = !rst && (!completing_byte || !word_valid || word_ready).
  - completing_byte is true when the next accepted byte would complete a word.
  - Consequence: when a load and a drain coincide, the output register reloads in the same cycle.
- Output register holds word_out, word_addr and word_last stable while word_valid && !word_ready.
- word_valid clears on drain unless a reload occurs in the same cycle.

## Timing
- Reset values: word_valid 0, word_out 0, word_addr 0, word_last 0, byte_ready 0 during rst; all counters and assembly register 0.
- byte_ready is 1 in the first cycle after rst deasserts.
- Latency: word_valid rises the cycle after the completing byte is accepted.
- Throughput: 1 byte/cycle sustained with word_ready held high. No bubbles at word or frame boundaries.
- Backpressure: with word_valid high and word_ready low, bytes for slots 0..2 of the next word are still accepted. byte_ready drops only when the next byte would complete a word.
- rst mid-frame discards the partial word, the pending output word and frame position. The next frame starts at word_addr 0, slot 0.
- byte_valid low for any number of cycles leaves all state unchanged.
- TOTAL_BYTES = 1: every byte produces a word with word_addr 0 and word_last 1.

## Test plan
- Mapping: bytes 0x01,0x00,0x00,0x00 -> word_out 0x80000000, word_addr 0. Bytes 0x01,0x02,0x04,0x80 -> 0x80402001. Bytes 0xA5,0x3C,0xFF,0x00 -> 0xA53CFF00.
- Padding (TOTAL_BYTES=6), bytes 0x01..0x06 -> 0x8040C020 (addr 0, last 0), then 0xA0600000 (addr 1, last 1). Next byte 0x01 begins a new frame at addr 0.
- Streaming (TOTAL_BYTES=436), 436 consecutive bytes with word_ready=1 -> 109 words, addr 0..108, word_last only on 108. byte_ready stays 1 throughout and there are no idle cycles.
- Backpressure: word_ready=0 after the first word -> exactly 3 further bytes accepted, then byte_ready=0 with word_out stable. Raising word_ready for one cycle drains word 0 and accepts the completing byte in the same cycle. The second word appears the next cycle.
- Reset mid-frame: 2 bytes accepted, rst for one cycle -> word_valid 0, word_out 0. Then bytes 0xFF,0x00,0x00,0x00 -> 0xFF000000 at addr 0.
- Idle gaps: random byte_valid and word_ready patterns over 3 frames against a reference model -> word sequence, addr and last identical to the model.
